// File: rtl/sp_ram_arbiter_if.sv
// Requester-side request/response bundle for sp_ram_arbiter.
// One instance per requester; the requester uses the master view,
// the arbiter the slave view.
interface sp_ram_arbiter_if #(
  parameter int AW = 3,
  parameter int DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single-port
// synchronous RAM (registered read data, one edge after addr is sampled).
// One transaction is in flight at a time: IDLE accepts a request, ISSUE
// presents it to the RAM, RDWAIT collects read data. Responses are a
// one-cycle pulse on the owning requester only.
module sp_ram_arbiter #(
  parameter int AW = 3,
  parameter int DW = 16
) (
  input  logic                wclk,
  input  logic                rst_n,
  sp_ram_arbiter_if.slave     a,
  sp_ram_arbiter_if.slave     b,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_din,
  output logic                ram_we,
  input  logic [DW-1:0]       ram_dout,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          owner_q, owner_d;
  logic          is_rd_q, is_rd_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          ram_we_q, ram_we_d;
  logic          a_rsp_valid_q, a_rsp_valid_d;
  logic [DW-1:0] a_rsp_rdata_q, a_rsp_rdata_d;
  logic          b_rsp_valid_q, b_rsp_valid_d;
  logic [DW-1:0] b_rsp_rdata_q, b_rsp_rdata_d;

  // Arbitration result and the fields of the winning request.
  logic          grant_b;
  logic          hs;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: reads need an extra cycle for the RAM's registered output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = ISSUE;
      ISSUE:   state_d = is_rd_q ? RDWAIT : IDLE;
      RDWAIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Winner selection and ready outputs; B wins only when A is absent or
  // A was granted last, so exactly one ready is high in IDLE.
  always_comb begin
    grant_b     = b.req_valid && (!a.req_valid || (last_grant_q == PORT_A));
    a.req_ready = 1'b0;
    b.req_ready = 1'b0;
    if (state_q == IDLE) begin
      a.req_ready = !grant_b;
      b.req_ready = grant_b;
    end
    hs        = (state_q == IDLE) && (grant_b ? b.req_valid : a.req_valid);
    sel_we    = grant_b ? b.req_we    : a.req_we;
    sel_addr  = grant_b ? b.req_addr  : a.req_addr;
    sel_wdata = grant_b ? b.req_wdata : a.req_wdata;
  end

  // Datapath next values: capture on handshake, pulse responses, and keep
  // ram_we confined to the single ISSUE cycle of a write.
  always_comb begin
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    is_rd_d       = is_rd_q;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    ram_we_d      = 1'b0;
    a_rsp_valid_d = 1'b0;
    b_rsp_valid_d = 1'b0;
    a_rsp_rdata_d = a_rsp_rdata_q;
    b_rsp_rdata_d = b_rsp_rdata_q;

    if (hs) begin
      ram_addr_d   = sel_addr;
      ram_din_d    = sel_wdata;
      ram_we_d     = sel_we;
      owner_d      = grant_b;
      is_rd_d      = !sel_we;
      last_grant_d = grant_b;
    end

    if ((state_q == ISSUE) && !is_rd_q) begin
      if (owner_q == PORT_B) begin
        b_rsp_valid_d = 1'b1;
      end else begin
        a_rsp_valid_d = 1'b1;
      end
    end

    if (state_q == RDWAIT) begin
      if (owner_q == PORT_B) begin
        b_rsp_valid_d = 1'b1;
        b_rsp_rdata_d = ram_dout;
      end else begin
        a_rsp_valid_d = 1'b1;
        a_rsp_rdata_d = ram_dout;
      end
    end
  end

  // Datapath registers; last_grant resets to B so A wins first contention.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q  <= PORT_B;
      owner_q       <= PORT_A;
      is_rd_q       <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_we_q      <= 1'b0;
      a_rsp_valid_q <= 1'b0;
      a_rsp_rdata_q <= '0;
      b_rsp_valid_q <= 1'b0;
      b_rsp_rdata_q <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      is_rd_q       <= is_rd_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      ram_we_q      <= ram_we_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      a_rsp_rdata_q <= a_rsp_rdata_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      b_rsp_rdata_q <= b_rsp_rdata_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign ram_we      = ram_we_q;
  assign a.rsp_valid = a_rsp_valid_q;
  assign a.rsp_rdata = a_rsp_rdata_q;
  assign b.rsp_valid = b_rsp_valid_q;
  assign b.rsp_rdata = b_rsp_rdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 8x16 synchronous single-port RAM (sp_ram8x16).
- Accepts read/write requests from ports A and B over a valid/ready handshake.
- Drives the RAM's addr/d_in/we ports from registers and returns read data, or a write acknowledge, as a one-cycle response pulse to the originating requester.
- Sits between the file-I/O/DSP stimulus engines and the shared RAM.

Parameters:
- AW, 3, RAM address width (depth 2**AW).
- DW, 16, RAM data width.

Ports:
- wclk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req_valid  in  1  requester A request present.
- a_req_ready  out  1  A request accepted this cycle.
- a_req_we  in  1  1=write, 0=read.
- a_req_addr  in  AW  A address.
- a_req_wdata  in  DW  A write data.
- a_rsp_valid  out  1  one-cycle response pulse to A.
- a_rsp_rdata  out  DW  read data to A (valid with a_rsp_valid on reads).
- b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_rdata: same as A, for requester B.
- ram_addr  out  AW  to RAM addr.
- ram_din  out  DW  to RAM d_in.
- ram_we  out  1  to RAM we.
- ram_dout  in  DW  from RAM d_out; registered by the RAM one edge after addr is sampled.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ram_we=0; ram_addr=0; ram_din=0.
  - a/b_rsp_valid=0; a/b_rsp_rdata=0.
  - last_grant=B, so A wins the first contention.
  - Reset mid-operation drops the in-flight request; no response is issued for it.
- States:
  - IDLE: x_req_ready is combinational and may be high only in IDLE. Winner selection:
    - Only one valid: that requester wins.
    - Both valid: the requester not equal to last_grant wins.
    - Exactly one ready is high per cycle.
  - Handshake at edge T (valid&&ready):
    - ram_addr<=req_addr, ram_din<=req_wdata, ram_we<=req_we.
    - Record owner and op; last_grant<=winner; state->ISSUE.
  - ISSUE (cycle T+1): RAM ports are stable and the RAM samples them at edge T+1. At that edge, ram_we<=0.
    - Write: owner's rsp_valid<=1 (pulse during T+2), rsp_rdata unchanged; state->IDLE.
    - Read: state->RDWAIT.
  - RDWAIT (cycle T+2): ram_dout holds mem[ram_addr]. At edge T+2: owner's rsp_rdata<=ram_dout, owner's rsp_valid<=1 (pulse during T+3); state->IDLE.
- Latency:
  - Write: ack pulse 2 cycles after the handshake edge.
  - Read: data pulse 3 cycles after the handshake edge.
- Throughput: next handshake may occur in the same cycle a response pulse is high. Max one write per 2 cycles, one read per 3 cycles.
- rsp_valid lasts exactly one cycle and is cleared the following edge.
- Non-owner rsp outputs are untouched.
- Requester rules: while valid and not ready, hold valid/we/addr/wdata stable. The arbiter samples them only on the handshake edge.
- Addresses wrap naturally at AW bits; no range checking.
- ram_we is high only during ISSUE cycles of write transactions, never in IDLE or RDWAIT.
- Fairness: under continuous contention, grants strictly alternate A,B,A,B; no requester waits more than one transaction.

Test Plan:
- Reset: assert rst_n=0 mid-ISSUE of a write -> ram_we=0, busy=0, no rsp pulse, state IDLE immediately (async), A wins next contention.
- Single write/read: A writes addr 3 data 16'hBEEF at T -> ram_we high only in T+1, a_rsp_valid pulse at T+2. A then reads addr 3 -> a_rsp_valid pulse with a_rsp_rdata=16'hBEEF 3 cycles after its handshake; b_rsp_valid stays 0.
- Contention: A and B hold reads of addr 1 and 2 continuously for 6 grants -> grant order A,B,A,B,A,B; each ready held exactly one cycle; responses return to the correct port.
- Back-to-back: B issues 8 writes, addr 0..7 data 16'h1000+i, valid held high -> handshakes every 2 cycles. Then B reads 0..7 -> b_rsp_rdata=16'h1000..16'h1007, handshakes every 3 cycles.
- Wrap: A writes addr 7 then 0 with 16'h7777/16'h0000; read-back matches, with no corruption of addr 6 or 1.
- Stability: B valid held while A is serviced with B's addr/data changing only after ready -> RAM sees only the sampled values; ram_we never high in IDLE or RDWAIT (assertion).
